// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth partial-product accumulator:
// digit-code layout, one-hot bit positions, FSM state encoding and a
// one-hot test helper.
package booth_pkg;

  // Width of a Booth digit code and the position of each one-hot selector
  localparam int CODE_W = 5;
  localparam int ZERO   = 4;  // 0x
  localparam int P2     = 3;  // +2x
  localparam int N2     = 2;  // -2x
  localparam int P1     = 1;  // +1x
  localparam int N1     = 0;  // -1x

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // True when exactly one bit of the code is set
  function automatic logic is_onehot(input logic [CODE_W-1:0] code);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < CODE_W; i++) begin
      ones += int'(code[i]);
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/booth_pp_select.sv
// Combinational Booth partial-product selector. Produces the 2*WIDTH-bit
// partial product (modulo 2^(2*WIDTH)) for one one-hot digit code and flags
// codes that are not one-hot; such codes select a zero partial product.
module booth_pp_select
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [CODE_W-1:0]  code,
  output logic [2*WIDTH-1:0] pp,
  output logic               illegal
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] cand  [CODE_W];
  logic [PW-1:0] term  [CODE_W];
  logic          legal;

  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
  assign legal = is_onehot(code);

  // Candidate multiples of A, one per selector bit
  assign cand[ZERO] = '0;
  assign cand[P1]   = a_ext;
  assign cand[N1]   = PW'(0) - a_ext;
  assign cand[P2]   = a_ext << 1;
  assign cand[N2]   = PW'(0) - (a_ext << 1);

  // Each selector bit gates its candidate; an illegal code gates all of them
  generate
    for (genvar gi = 0; gi < CODE_W; gi++) begin : g_term
      assign term[gi] = (legal && code[gi]) ? cand[gi] : '0;
    end
  endgenerate

  // OR-combine the gated candidates (at most one is non-zero)
  always_comb begin
    pp = '0;
    for (int i = 0; i < CODE_W; i++) begin
      pp = pp | term[i];
    end
    illegal = ~legal;
  end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Radix-4 Booth partial-product accumulator. Accepts a signed multiplicand,
// then NDIG one-hot Booth digit codes (least-significant first), summing
// pp << 2*k into a 2*WIDTH-bit accumulator, and presents the product with a
// valid/ready handshake. Non-one-hot codes add zero and raise a sticky error.
module booth_pp_accumulator
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NDIG  = WIDTH / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic                 code_valid,
  output logic                 code_ready,
  input  logic [CODE_W-1:0]    code,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 code_err
);

  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     a_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 code_err_reg;

  logic [2*WIDTH-1:0]   pp;
  logic                 pp_illegal;
  logic [CNT_W:0]       shift_amt;
  logic                 start_fire;
  logic                 code_fire;

  booth_pp_select #(
    .WIDTH (WIDTH)
  ) u_select (
    .a       (a_reg),
    .code    (code),
    .pp      (pp),
    .illegal (pp_illegal)
  );

  // Digit k carries weight 4^k, i.e. a left shift of 2*k bits
  assign shift_amt  = {cnt_reg, 1'b0};
  assign start_fire = start_valid & start_ready;
  assign code_fire  = code_valid & code_ready;

  assign result   = acc_reg;
  assign code_err = code_err_reg;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs; all ready/valid held low during reset
  always_comb begin
    state_next   = state_reg;
    start_ready  = 1'b0;
    code_ready   = 1'b0;
    result_valid = 1'b0;
    unique case (state_reg)
      IDLE: begin
        start_ready = ~rst;
        if (start_valid && !rst) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        code_ready = ~rst;
        if (code_valid && !rst && (cnt_reg == LAST_CNT)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        result_valid = ~rst;
        if (result_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: capture A on start, accumulate shifted partial products on digits
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg        <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      code_err_reg <= 1'b0;
    end else if (start_fire) begin
      a_reg        <= multiplicand;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      code_err_reg <= 1'b0;
    end else if (code_fire) begin
      acc_reg <= acc_reg + (pp << shift_amt);
      cnt_reg <= (cnt_reg == LAST_CNT) ? '0 : cnt_reg + 1'b1;
      if (pp_illegal) begin
        code_err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Self-checking bench for booth_pp_accumulator (WIDTH=8, NDIG=4).
// Expected products come from digit-value arithmetic or from A*B directly.
module tb_booth_pp_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [7:0]  multiplicand;
  logic        code_valid;
  logic        code_ready;
  logic [4:0]  code;
  logic        result_valid;
  logic        result_ready;
  logic [15:0] result;
  logic        code_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  booth_pp_accumulator #(
    .WIDTH (8),
    .NDIG  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .multiplicand (multiplicand),
    .code_valid   (code_valid),
    .code_ready   (code_ready),
    .code         (code),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .code_err     (code_err)
  );

  // Reference: sum of digit_value * A * 4^k, modulo 2^16
  function automatic logic [15:0] model_product(input logic signed [7:0] a,
                                                input logic [3:0][4:0] codes,
                                                output bit err);
    longint sum;
    longint d;
    sum = 0;
    err = 0;
    for (int k = 0; k < 4; k++) begin
      case (codes[k])
        5'b10000: d = 0;
        5'b01000: d = 2;
        5'b00100: d = -2;
        5'b00010: d = 1;
        5'b00001: d = -1;
        default: begin d = 0; err = 1; end
      endcase
      sum += d * longint'(a) * (longint'(1) << (2 * k));
    end
    return sum[15:0];
  endfunction

  // Radix-4 Booth recoding of an 8-bit multiplier into one-hot digit codes
  function automatic logic [3:0][4:0] booth_encode(input logic [7:0] b);
    logic [8:0] bx;
    logic [3:0][4:0] codes;
    int d;
    bx = {b, 1'b0};
    for (int k = 0; k < 4; k++) begin
      d = -2 * int'(bx[2*k+2]) + int'(bx[2*k+1]) + int'(bx[2*k]);
      case (d)
        2:       codes[k] = 5'b01000;
        1:       codes[k] = 5'b00010;
        -1:      codes[k] = 5'b00001;
        -2:      codes[k] = 5'b00100;
        default: codes[k] = 5'b10000;
      endcase
    end
    return codes;
  endfunction

  // Start handshake; returns at the negedge of the cycle after the handshake
  task automatic drive_start(input logic [7:0] a);
    int waited;
    multiplicand = a;
    start_valid  = 1'b1;
    waited = 0;
    while (!start_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!start_ready) begin
      total++;
      $display("FAIL start_timeout: start_ready=%b required 1", start_ready);
    end
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  // Feed four digit codes; optional random stalls. Reports result_valid seen early.
  task automatic drive_codes(input logic [3:0][4:0] codes, input bit gaps,
                             output bit rv_early);
    int stalls;
    rv_early = 0;
    for (int k = 0; k < 4; k++) begin
      if (gaps) begin
        stalls = $urandom_range(0, 2);
        for (int s = 0; s < stalls; s++) begin
          code_valid = 1'b0;
          code = 5'($urandom);
          if (result_valid) rv_early = 1;
          @(negedge clk);
        end
      end
      code_valid = 1'b1;
      code = codes[k];
      if (result_valid) rv_early = 1;
      @(negedge clk);
    end
    code_valid = 1'b0;
    code = '0;
  endtask

  task automatic take_result();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (start_ready !== 1'b0) $display("FAIL reset_start_ready: got %b required 0", start_ready); else passed++;
    total++; if (code_ready !== 1'b0) $display("FAIL reset_code_ready: got %b required 0", code_ready); else passed++;
    total++; if (result_valid !== 1'b0) $display("FAIL reset_result_valid: got %b required 0", result_valid); else passed++;
    total++; if (result !== 16'h0000) $display("FAIL reset_result: got %h required 0000", result); else passed++;
    total++; if (code_err !== 1'b0) $display("FAIL reset_code_err: got %b required 0", code_err); else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++; if (start_ready !== 1'b1) $display("FAIL post_reset_start_ready: got %b required 1", start_ready); else passed++;
    $display("txn reset done");
  endtask

  task automatic test_directed();
    logic [7:0]      a_tab [4];
    logic [3:0][4:0] c_tab [4];
    logic [15:0]     r_tab [4];
    bit              e_tab [4];
    logic [15:0]     exp_r;
    bit              exp_e;
    bit              early;
    a_tab[0] = 8'd7;   c_tab[0] = {5'b10000, 5'b10000, 5'b01000, 5'b00100}; r_tab[0] = 16'h002A; e_tab[0] = 0;
    a_tab[1] = 8'h80;  c_tab[1] = {5'b00100, 5'b10000, 5'b10000, 5'b10000}; r_tab[1] = 16'h4000; e_tab[1] = 0;
    a_tab[2] = 8'h80;  c_tab[2] = {5'b10000, 5'b10000, 5'b10000, 5'b01000}; r_tab[2] = 16'hFF00; e_tab[2] = 0;
    a_tab[3] = 8'd5;   c_tab[3] = {5'b10000, 5'b10000, 5'b10000, 5'b00011}; r_tab[3] = 16'h0000; e_tab[3] = 1;
    for (int t = 0; t < 4; t++) begin
      exp_r = model_product(a_tab[t], c_tab[t], exp_e);
      if (exp_r !== r_tab[t] || exp_e !== e_tab[t])
        $display("note: model disagrees with table entry %0d", t);
      drive_start(a_tab[t]);
      drive_codes(c_tab[t], 1'b0, early);
      // Back-to-back digits: valid appears exactly in cycle NDIG+1
      total++; if (early !== 1'b0) $display("FAIL dir%0d_early_valid: got %b required 0", t, early); else passed++;
      total++; if (result_valid !== 1'b1) $display("FAIL dir%0d_valid: got %b required 1", t, result_valid); else passed++;
      total++; if (result !== r_tab[t]) $display("FAIL dir%0d_result: got %h required %h", t, result, r_tab[t]); else passed++;
      total++; if (code_err !== e_tab[t]) $display("FAIL dir%0d_code_err: got %b required %b", t, code_err, e_tab[t]); else passed++;
      $display("txn directed A=%0d codes=%h result=%h err=%b", $signed(a_tab[t]), c_tab[t], result, code_err);
      take_result();
    end
    // A legal product after the illegal one clears code_err
    drive_start(8'd3);
    drive_codes({5'b10000, 5'b10000, 5'b10000, 5'b00010}, 1'b0, early);
    total++; if (code_err !== 1'b0) $display("FAIL err_cleared: got %b required 0", code_err); else passed++;
    total++; if (result !== 16'h0003) $display("FAIL err_cleared_result: got %h required 0003", result); else passed++;
    $display("txn directed A=3 result=%h err=%b", result, code_err);
    take_result();
  endtask

  task automatic test_backpressure();
    logic [7:0]      a, b;
    logic [15:0]     exp_r;
    bit              early;
    a = 8'($urandom); b = 8'($urandom);
    exp_r = 16'($signed(a) * $signed(b));
    drive_start(a);
    drive_codes(booth_encode(b), 1'b1, early);
    total++; if (early !== 1'b0) $display("FAIL bp_early_valid: got %b required 0", early); else passed++;
    for (int c = 0; c < 3; c++) begin
      code_valid = 1'b1; code = 5'b01000;
      total++; if (result_valid !== 1'b1 || result !== exp_r)
        $display("FAIL bp_hold%0d: valid=%b result=%h required 1/%h", c, result_valid, result, exp_r); else passed++;
      total++; if (start_ready !== 1'b0 || code_ready !== 1'b0)
        $display("FAIL bp_ready%0d: start_ready=%b code_ready=%b required 0/0", c, start_ready, code_ready); else passed++;
      @(negedge clk);
    end
    code_valid = 1'b0;
    total++; if (result !== exp_r) $display("FAIL bp_done_code_ignored: got %h required %h", result, exp_r); else passed++;
    take_result();
    total++; if (result_valid !== 1'b0) $display("FAIL bp_single_handshake: got %b required 0", result_valid); else passed++;
    total++; if (start_ready !== 1'b1) $display("FAIL bp_start_ready: got %b required 1", start_ready); else passed++;
    $display("txn backpressure A=%0d B=%0d result=%h", $signed(a), $signed(b), exp_r);
  endtask

  task automatic test_mid_reset();
    bit  early;
    bit  seen;
    logic [3:0][4:0] codes;
    drive_start(8'd9);
    code_valid = 1'b1; code = 5'b01000; @(negedge clk);
    code = 5'b00010; @(negedge clk);
    code_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (result_valid !== 1'b0) $display("FAIL midrst_valid_in_reset: got %b required 0", result_valid); else passed++;
    @(negedge clk);
    total++; if (start_ready !== 1'b1) $display("FAIL midrst_idle: start_ready=%b required 1", start_ready); else passed++;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (result_valid) seen = 1;
      @(negedge clk);
    end
    total++; if (seen !== 1'b0) $display("FAIL midrst_no_valid: got %b required 0", seen); else passed++;
    codes = booth_encode(8'hF3);
    drive_start(8'd11);
    drive_codes(codes, 1'b0, early);
    total++; if (result !== 16'($signed(8'd11) * $signed(8'hF3)))
      $display("FAIL midrst_fresh: got %h required %h", result, 16'($signed(8'd11) * $signed(8'hF3))); else passed++;
    $display("txn midreset fresh A=11 B=-13 result=%h", result);
    take_result();
  endtask

  task automatic test_idle_codes();
    bit early;
    code_valid = 1'b1; code = 5'b01000;
    for (int c = 0; c < 3; c++) begin
      total++; if (code_ready !== 1'b0) $display("FAIL idle_code_ready: got %b required 0", code_ready); else passed++;
      @(negedge clk);
    end
    code_valid = 1'b0;
    drive_start(8'd6);
    drive_codes(booth_encode(8'd10), 1'b0, early);
    total++; if (result !== 16'd60) $display("FAIL idle_codes_ignored: got %h required %h", result, 16'd60); else passed++;
    $display("txn idle-codes A=6 B=10 result=%h", result);
    take_result();
  endtask

  task automatic test_random();
    logic [7:0]  a, b;
    logic [15:0] exp_r;
    bit          early;
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom); b = 8'($urandom);
      if (n == 0) begin a = 8'h80; b = 8'h80; end
      if (n == 1) begin a = 8'h7F; b = 8'h80; end
      exp_r = 16'($signed(a) * $signed(b));
      drive_start(a);
      drive_codes(booth_encode(b), 1'($urandom), early);
      total++; if (result_valid !== 1'b1 || result !== exp_r || code_err !== 1'b0)
        $display("FAIL rand%0d: valid=%b result=%h err=%b required 1/%h/0", n, result_valid, result, code_err, exp_r);
      else passed++;
      $display("txn random A=%0d B=%0d result=%h", $signed(a), $signed(b), result);
      take_result();
    end
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; multiplicand = '0;
    code_valid = 1'b0; code = '0; result_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_mid_reset();
    test_idle_codes();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
